// File: rtl/duty_pkg.sv
// Shared constants and the phase-state encoding for the duty-cycle divider
// and its checker.
package duty_pkg;

    localparam int unsigned DUTY_SCALE = 32'd1000;
    localparam int unsigned DUTY_ROUND = 32'd500;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

endpackage

// File: rtl/duty_cycle_check.sv
// Monitor for the divided clock: once LOCKED, each measured period and high
// time must match the configuration; any mismatch latches fail until reset.
module duty_cycle_check
    import duty_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             clk,
    input  logic             LOCKED,
    input  logic [DIV_W-1:0] divide,
    input  logic [31:0]      desired_duty_cycle_1000,
    output logic             fail
);

    localparam int PW = DIV_W + 33;

    logic             clk_prev_q;
    logic             seen_q;
    logic             fail_q;
    logic [DIV_W:0]   per_q;
    logic [DIV_W:0]   hi_q;
    logic [PW-1:0]    exp_raw_s;
    logic [DIV_W:0]   exp_hi_s;
    logic             rise_s;

    // Expected high time from the configuration, plus rising-edge detect.
    always_comb begin
        rise_s    = clk & ~clk_prev_q;
        exp_raw_s = (PW'(divide) * PW'(desired_duty_cycle_1000) + PW'(DUTY_ROUND))
                    / PW'(DUTY_SCALE);
        if (exp_raw_s == '0) begin
            exp_hi_s = (DIV_W + 1)'(1);
        end else if (exp_raw_s >= PW'(divide)) begin
            exp_hi_s = {1'b0, divide} - (DIV_W + 1)'(1);
        end else begin
            exp_hi_s = exp_raw_s[DIV_W:0];
        end
    end

    // Measure period and high time between rising edges of the divided clock.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            clk_prev_q <= 1'b0;
            seen_q     <= 1'b0;
            fail_q     <= 1'b0;
            per_q      <= '0;
            hi_q       <= '0;
        end else begin
            clk_prev_q <= clk;
            if (rise_s) begin
                seen_q <= 1'b1;
                per_q  <= (DIV_W + 1)'(1);
                hi_q   <= (DIV_W + 1)'(1);
                if (seen_q && LOCKED && ((per_q != {1'b0, divide}) || (hi_q != exp_hi_s))) begin
                    fail_q <= 1'b1;
                end else begin
                    fail_q <= fail_q;
                end
            end else begin
                if (per_q != '1) begin
                    per_q <= per_q + (DIV_W + 1)'(1);
                end else begin
                    per_q <= per_q;
                end
                if (clk && (hi_q != '1)) begin
                    hi_q <= hi_q + (DIV_W + 1)'(1);
                end else begin
                    hi_q <= hi_q;
                end
            end
        end
    end

    assign fail = fail_q;

endmodule

// File: rtl/duty_high_calc.sv
// Combinational high-time computation: rounded divide*duty/1000, clamped so
// both phases last at least one cycle, plus the configuration validity flag.
module duty_high_calc
    import duty_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic [DIV_W-1:0] divide_i,
    input  logic [31:0]      duty_i,
    output logic [DIV_W-1:0] high_o,
    output logic             valid_o
);

    // One extra bit beyond DIV_W+32 keeps the rounding add from overflowing.
    localparam int PW = DIV_W + 33;

    logic [PW-1:0] prod_s;
    logic [PW-1:0] raw_s;

    // Multiply, round, clamp and validate the requested configuration.
    always_comb begin
        prod_s  = PW'(divide_i) * PW'(duty_i);
        raw_s   = (prod_s + PW'(DUTY_ROUND)) / PW'(DUTY_SCALE);
        valid_o = (divide_i >= DIV_W'(2)) && (duty_i <= 32'(DUTY_SCALE));
        if (raw_s == '0) begin
            high_o = DIV_W'(1);
        end else if (raw_s >= PW'(divide_i)) begin
            high_o = divide_i - DIV_W'(1);
        end else begin
            high_o = raw_s[DIV_W-1:0];
        end
    end

endmodule

// File: rtl/duty_cycle_divider.sv
// Programmable clock divider with duty-cycle control: a HIGH/LOW phase FSM that
// samples its configuration only at period boundaries and reports lock.
module duty_cycle_divider
    import duty_pkg::*;
#(
    parameter int DIV_W        = 8,
    parameter int LOCK_PERIODS = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] divide,
    input  logic [31:0]      desired_duty_cycle_1000,
    input  logic             enable,
    output logic             clk_out,
    output logic             locked,
    output logic             cfg_error,
    output logic [DIV_W-1:0] high_cycles
);

    localparam int LOCK_W = (LOCK_PERIODS < 1) ? 1 : $clog2(LOCK_PERIODS + 1);
    localparam logic [LOCK_W-1:0] LOCK_TARGET = LOCK_W'(LOCK_PERIODS);

    state_e            state_q;
    logic [DIV_W-1:0]  cnt_q;
    logic [DIV_W-1:0]  div_q;
    logic [31:0]       duty_q;
    logic [DIV_W-1:0]  high_q;
    logic [LOCK_W-1:0] lock_cnt_q;
    logic [LOCK_W-1:0] lock_cnt_d;
    logic              locked_q;
    logic              cfg_err_q;
    logic              clk_out_q;

    logic [DIV_W-1:0]  calc_high_s;
    logic              cfg_valid_s;
    logic              high_end_s;
    logic              low_end_s;
    logic              sample_s;
    logic              same_cfg_s;

    duty_high_calc #(
        .DIV_W (DIV_W)
    ) u_high_calc (
        .divide_i (divide),
        .duty_i   (desired_duty_cycle_1000),
        .high_o   (calc_high_s),
        .valid_o  (cfg_valid_s)
    );

    // Phase-end detection and boundary sampling decisions.
    always_comb begin
        high_end_s = (state_q == HIGH) && (cnt_q == high_q - DIV_W'(1));
        low_end_s  = (state_q == LOW) && (cnt_q == div_q - high_q - DIV_W'(1));
        sample_s   = enable && ((state_q == IDLE) || low_end_s);
        same_cfg_s = (state_q == LOW) && (divide == div_q) && (desired_duty_cycle_1000 == duty_q);
        lock_cnt_d = (lock_cnt_q >= LOCK_TARGET) ? lock_cnt_q : lock_cnt_q + LOCK_W'(1);
    end

    // FSM, phase counter and lock counter; clk_out trails the phase by one cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            duty_q     <= 32'd0;
            high_q     <= '0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            cfg_err_q  <= 1'b0;
            clk_out_q  <= 1'b0;
        end else begin
            clk_out_q <= (state_q == HIGH);
            if (sample_s) begin
                cnt_q <= '0;
                if (cfg_valid_s) begin
                    state_q   <= HIGH;
                    div_q     <= divide;
                    duty_q    <= desired_duty_cycle_1000;
                    high_q    <= calc_high_s;
                    cfg_err_q <= 1'b0;
                    if (same_cfg_s) begin
                        lock_cnt_q <= lock_cnt_d;
                        locked_q   <= (lock_cnt_d >= LOCK_TARGET);
                    end else begin
                        lock_cnt_q <= '0;
                        locked_q   <= 1'b0;
                    end
                end else begin
                    state_q    <= IDLE;
                    cfg_err_q  <= 1'b1;
                    lock_cnt_q <= '0;
                    locked_q   <= 1'b0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_q      <= '0;
                        lock_cnt_q <= '0;
                        locked_q   <= 1'b0;
                    end
                    HIGH: begin
                        if (high_end_s) begin
                            state_q <= LOW;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + DIV_W'(1);
                        end
                    end
                    LOW: begin
                        if (low_end_s) begin
                            state_q    <= IDLE;
                            cnt_q      <= '0;
                            lock_cnt_q <= '0;
                            locked_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + DIV_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign clk_out     = clk_out_q;
    assign locked      = locked_q;
    assign cfg_error   = cfg_err_q;
    assign high_cycles = high_q;

endmodule

// File: tb/tb_duty_cycle_divider.sv
// Randomized self-checking bench: a queue-based period model predicts every
// output cycle by cycle, with directed scenarios for the boundary cases.
module tb_duty_cycle_divider;

    localparam int DIV_W = 8;
    localparam int LP    = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [DIV_W-1:0] divide;
    logic [31:0]      duty;
    logic             enable;
    logic             clk_out;
    logic             locked;
    logic             cfg_error;
    logic [DIV_W-1:0] high_cycles;
    logic             chk_fail;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: pending per-cycle phase bits of the current period.
    bit              m_q[$];
    bit              m_st;
    bit              m_clk;
    bit              m_locked;
    bit              m_err;
    bit              m_active;
    int              m_high_v;
    int              m_lock;
    int              m_pd;
    longint unsigned m_pduty;

    duty_cycle_divider #(
        .DIV_W        (DIV_W),
        .LOCK_PERIODS (LP)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .divide                  (divide),
        .desired_duty_cycle_1000 (duty),
        .enable                  (enable),
        .clk_out                 (clk_out),
        .locked                  (locked),
        .cfg_error               (cfg_error),
        .high_cycles             (high_cycles)
    );

    duty_cycle_check #(
        .DIV_W (DIV_W)
    ) u_check (
        .sys_clk                 (clk),
        .rst_n                   (reset_n),
        .clk                     (clk_out),
        .LOCKED                  (locked),
        .divide                  (divide),
        .desired_duty_cycle_1000 (duty),
        .fail                    (chk_fail)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int m_high(input int d, input longint unsigned dc);
        longint unsigned r;
        r = (longint'(d) * dc + 500) / 1000;
        if (r < 1) r = 1;
        if (r > longint'(d - 1)) r = longint'(d - 1);
        return int'(r);
    endfunction

    task automatic model_edge();
        int  h;
        bit  same;
        if (!reset_n) begin
            m_q.delete();
            m_st = 0; m_clk = 0; m_locked = 0; m_err = 0;
            m_high_v = 0; m_lock = 0; m_active = 0;
        end else begin
            if (m_q.size() == 0) begin
                if (enable) begin
                    if (divide >= 2 && duty <= 1000) begin
                        h = m_high(int'(divide), longint'(duty));
                        same = m_active && (int'(divide) == m_pd) && (longint'(duty) == m_pduty);
                        m_lock   = same ? ((m_lock < LP) ? m_lock + 1 : m_lock) : 0;
                        m_locked = (m_lock >= LP);
                        m_active = 1; m_err = 0; m_high_v = h;
                        m_pd = int'(divide); m_pduty = longint'(duty);
                        for (int i = 0; i < h; i++) m_q.push_back(1'b1);
                        for (int i = h; i < int'(divide); i++) m_q.push_back(1'b0);
                    end else begin
                        m_active = 0; m_err = 1; m_locked = 0; m_lock = 0;
                    end
                end else begin
                    m_active = 0; m_locked = 0; m_lock = 0;
                end
            end
            m_clk = m_st;
            m_st  = (m_q.size() > 0) ? m_q.pop_front() : 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("clk_out",     {31'd0, clk_out},   {31'd0, m_clk});
        check_eq("locked",      {31'd0, locked},    {31'd0, m_locked});
        check_eq("cfg_error",   {31'd0, cfg_error}, {31'd0, m_err});
        check_eq("high_cycles", {24'd0, high_cycles}, 32'(m_high_v));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until clk_out makes a transition to lvl, bounded by a cycle budget.
    task automatic wait_edge(input logic lvl, input string tag);
        int   n;
        logic prev;
        n = 0;
        prev = clk_out;
        while (!(prev !== lvl && clk_out === lvl) && n < 40) begin
            prev = clk_out;
            step();
            n++;
        end
        check_eq(tag, {31'd0, (n < 40)}, 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; divide = 8'd10; duty = 32'd500;
        run(3);
        reset_n = 1'b1;
        run(2);

        // 10 / 50 %: 5 high, 5 low, lock after two periods, monitor quiet
        enable = 1'b1;
        run(45);
        check_eq("lock_10_500", {31'd0, locked}, 32'd1);
        check_eq("high_10_500", {24'd0, high_cycles}, 32'd5);
        check_eq("monitor_fail", {31'd0, chk_fail}, 32'd0);

        // divide change mid-HIGH only takes effect at the next boundary
        wait_edge(1'b1, "wait_rise");
        step();
        divide = 8'd6;
        run(40);
        check_eq("lock_after_change", {31'd0, locked}, 32'd1);
        check_eq("high_6_500", {24'd0, high_cycles}, 32'd3);

        divide = 8'd7; duty = 32'd333;
        run(25);
        check_eq("high_7_333", {24'd0, high_cycles}, 32'd2);

        divide = 8'd4; duty = 32'd0;
        run(12);
        check_eq("high_4_0", {24'd0, high_cycles}, 32'd1);
        duty = 32'd1000;
        run(12);
        check_eq("high_4_1000", {24'd0, high_cycles}, 32'd3);
        check_eq("err_4_1000", {31'd0, cfg_error}, 32'd0);

        // invalid configurations, then recovery
        divide = 8'd1;
        run(8);
        check_eq("err_div1", {31'd0, cfg_error}, 32'd1);
        divide = 8'd8; duty = 32'd1001;
        run(4);
        check_eq("err_duty1001", {31'd0, cfg_error}, 32'd1);
        duty = 32'd500;
        run(4);
        check_eq("err_cleared", {31'd0, cfg_error}, 32'd0);

        // one-cycle reset mid-LOW of divide 8
        run(16);
        wait_edge(1'b0, "wait_fall");
        step();
        reset_n = 1'b0;
        step();
        check_eq("rst_clk_out", {31'd0, clk_out}, 32'd0);
        reset_n = 1'b1;
        step();
        check_eq("rst_restart_1", {31'd0, clk_out}, 32'd0);
        step();
        check_eq("rst_restart_2", {31'd0, clk_out}, 32'd1);

        // randomized segments against the model
        for (int s = 0; s < 250; s++) begin
            case ($urandom_range(0, 9))
                0:       divide = 8'($urandom_range(0, 1));
                1:       divide = 8'($urandom_range(200, 255));
                default: divide = 8'($urandom_range(2, 20));
            endcase
            duty    = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(1001, 5000))
                                                   : 32'($urandom_range(0, 1000));
            enable  = ($urandom_range(0, 5) != 0);
            reset_n = ($urandom_range(0, 30) != 0);
            step();
            reset_n = 1'b1;
            run($urandom_range(1, 60));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/duty_cycle_divider.md
DUTY_CYCLE_DIVIDER -- requirements
Module: duty_cycle_divider

Interface
REQ-001 Parameter DIV_W, default 8, sets the width of the divide input.
REQ-002 Parameter LOCK_PERIODS, default 2, is the number of complete stable output periods required before locked rises.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 divide  input  DIV_W  output period in clk cycles; valid range 2..2^DIV_W-1.
REQ-006 desired_duty_cycle_1000  input  32  high fraction times 1000 (500 = 50 %); valid range 0..1000.
REQ-007 enable  input  1  1 = generate output; 0 = finish the current period, then idle.
REQ-008 clk_out  output  1  divided clock, registered.
REQ-009 locked  output  1  output period and duty cycle stable for LOCK_PERIODS periods.
REQ-010 cfg_error  output  1  the last sampled configuration was invalid.
REQ-011 high_cycles  output  DIV_W  high time currently in effect, in clk cycles.

Function
REQ-012 high_cycles SHALL be computed as (divide * desired_duty_cycle_1000 + 500) / 1000, using an unsigned product of at least DIV_W+32 bits with no overflow.
REQ-013 The high_cycles result SHALL then be clamped to the range 1..divide-1.
REQ-014 The configuration is invalid if divide < 2 or desired_duty_cycle_1000 > 1000.
REQ-015 The FSM SHALL have exactly three states: IDLE, HIGH and LOW.
REQ-016 In IDLE, clk_out = 0 and the counter = 0; if enable = 1, the FSM samples the configuration on that edge.
REQ-017 From IDLE with a valid configuration, the FSM enters HIGH on the next cycle.
REQ-018 From IDLE with an invalid configuration, the FSM stays in IDLE and sets cfg_error.
REQ-019 In HIGH, clk_out = 1 for exactly high_cycles clk cycles, then the FSM enters LOW.
REQ-020 In LOW, clk_out = 0 for exactly divide - high_cycles cycles.
REQ-021 At the end of LOW, the FSM re-samples the configuration if enable = 1, else it returns to IDLE.
REQ-022 The configuration SHALL be sampled only at period boundaries (IDLE exit or LOW end); input changes mid-period do not affect the current period.
REQ-023 If a re-sample is invalid, the FSM goes to IDLE, sets cfg_error = 1 and clears locked; cfg_error clears on the next valid sample.
REQ-024 Deasserting enable mid-period SHALL NOT truncate the current period.
REQ-025 The first rising edge of clk_out SHALL occur 1 clk cycle after the enable sample in IDLE.
REQ-026 Counter behaviour: the counter is DIV_W bits, counts 0..N-1 per phase and resets to 0 on each phase change; no wrap-around occurs within a phase.
REQ-027 A lock counter SHALL increment at each completed period whose sampled configuration equals the previous period's.
REQ-028 locked SHALL rise on the boundary where the lock counter reaches LOCK_PERIODS.
REQ-029 A configuration change at a boundary SHALL clear locked and the lock counter in the same cycle.
REQ-030 locked SHALL fall when the FSM enters IDLE.
REQ-031 If enable falls and the configuration changes in the same cycle at a boundary, the FSM goes to IDLE and locked = 0.
REQ-032 clk_out period SHALL equal divide clk cycles exactly, so an externally measured period equals divide * T_clk.

Reset
REQ-033 While reset_n = 0 at a rising clk edge, the following values apply on the next edge:
- state = IDLE
- clk_out = 0
- locked = 0
- cfg_error = 0
- high_cycles = 0
- all counters = 0
REQ-034 Assertion of reset_n mid-period SHALL abort the period immediately with no partial-pulse completion.
REQ-035 Operation SHALL restart from IDLE on the first edge with reset_n = 1.

Structure
REQ-036 Shared package duty_pkg SHALL hold:
- DUTY_SCALE = 1000
- DUTY_ROUND = 500
- the state enum {IDLE, HIGH, LOW}
REQ-037 duty_cycle_check SHALL use the same DUTY_SCALE constant from duty_pkg.
REQ-038 One sub-module, duty_high_calc, SHALL hold the combinational multiply, round, clamp and validity logic.
REQ-039 The top level SHALL contain only the FSM, the phase counter and the lock counter.
REQ-040 clk_out and the duty_cycle_divider locked output SHALL connect directly to the clk and LOCKED inputs of duty_cycle_check in the bench.

Verification
REQ-041 divide = 10, duty = 500, enable = 1 -> clk_out 5 high / 5 low, locked = 1 after 2 periods, and duty_cycle_check fail = 0.
REQ-042 divide = 7, duty = 333 -> high_cycles = 2 (2331 rounds to 2); 2 high / 5 low.
REQ-043 divide = 4, duty = 0 and duty = 1000 -> clamped to high_cycles = 1 and 3 respectively; cfg_error = 0.
REQ-044 divide changes from 10 to 6 mid-HIGH -> current period stays 10 cycles, next period is 6 cycles, locked drops at the boundary and returns 2 periods later.
REQ-045 divide = 1 or duty = 1001 -> cfg_error = 1, clk_out stays 0 and locked = 0; a subsequent valid configuration clears cfg_error.
REQ-046 reset_n pulsed low for 1 cycle mid-LOW of divide = 8 -> all outputs 0 on the next edge; first rising edge of clk_out 2 cycles after reset_n returns high.
